// File: rtl/dmem_responder.sv
// dmem_responder: wait-state data-memory target for the pipeline's memory stage.
// Accepts one load/store at a time and holds it for LATENCY cycles.
// It then completes the access with a one-cycle valid pulse.
// Optional feature macro: DMEM_RESP_RANGE_CHK_EN. It adds the err port and
// suppresses accesses whose word index is DEPTH or above. Without the macro,
// the word index wraps modulo DEPTH.
module dmem_responder #(
   parameter int DEPTH   = 1024,
   parameter int LATENCY = 2
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [31:0] addr,
   input  logic [31:0] data_wr,
   input  logic        cs,
   input  logic        rd,
   input  logic [3:0]  mask,
   output logic [31:0] data_rd,
   output logic        valid,
   output logic        busy
`ifdef DMEM_RESP_RANGE_CHK_EN
   ,
   output logic        err
`endif
);

   localparam int IDX_W = $clog2(DEPTH);

   typedef enum logic [1:0] {IDLE, WAIT, DONE} state_t;

   state_t      state;
   logic [3:0]  cnt;

   logic [29:0] req_word;
   logic [31:0] req_data;
   logic        req_rd;
   logic [3:0]  req_mask;

   logic [31:0] mem [DEPTH];

   logic [29:0] acc_word;
   logic [31:0] acc_data;
   logic        acc_rd;
   logic [3:0]  acc_mask;
   logic        go_done;
   logic        in_range;
   logic [31:0] rd_word;
   logic [31:0] load_val;

`ifdef DMEM_RESP_RANGE_CHK_EN
   assign in_range = ~|acc_word[29:IDX_W];
   logic unused_bits;
   assign unused_bits = ^addr[1:0];
`else
   assign in_range = 1'b1;
   logic unused_bits;
   assign unused_bits = ^{addr[1:0], acc_word[29:IDX_W]};
`endif

   // Access being completed this cycle: live inputs on a LATENCY=1 accept, captured request otherwise
   always_comb begin
      acc_word = req_word;
      acc_data = req_data;
      acc_rd   = req_rd;
      acc_mask = req_mask;
      if (state == IDLE) begin
         acc_word = addr[31:2];
         acc_data = data_wr;
         acc_rd   = rd;
         acc_mask = mask;
      end
   end

   // The edge that enters DONE commits the store or samples the load
   assign go_done = ~reset & (((state == IDLE) & cs & (LATENCY == 1)) |
                              ((state == WAIT) & (cnt == 4'd0)));

   assign rd_word = mem[acc_word[IDX_W-1:0]];

   // Load data with disabled lanes forced to zero; out-of-range loads read as zero
   always_comb begin
      load_val = 32'h0;
      for (int i = 0; i < 4; i++) begin
         if (acc_mask[i]) load_val[8*i +: 8] = rd_word[8*i +: 8];
      end
      if (!in_range) load_val = 32'h0;
   end

   // Capture the request on acceptance; held untouched through WAIT and DONE
   always_ff @(posedge clk) begin
      if (state == IDLE && cs) begin
         req_word <= addr[31:2];
         req_data <= data_wr;
         req_rd   <= rd;
         req_mask <= mask;
      end
   end

   // Byte-lane store commit; array contents survive reset
   always_ff @(posedge clk) begin
      if (go_done && !acc_rd && in_range) begin
         for (int i = 0; i < 4; i++) begin
            if (acc_mask[i]) mem[acc_word[IDX_W-1:0]][8*i +: 8] <= acc_data[8*i +: 8];
         end
      end
   end

   // Request sequencer with registered valid/busy/data_rd outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state   <= IDLE;
         cnt     <= 4'd0;
         valid   <= 1'b0;
         busy    <= 1'b0;
         data_rd <= 32'h0;
`ifdef DMEM_RESP_RANGE_CHK_EN
         err     <= 1'b0;
`endif
      end else begin
         valid <= go_done;
`ifdef DMEM_RESP_RANGE_CHK_EN
         err   <= go_done & ~in_range;
`endif
         if (go_done && acc_rd) data_rd <= load_val;
         case (state)
            IDLE: begin
               if (cs) begin
                  busy <= 1'b1;
                  if (LATENCY == 1) begin
                     state <= DONE;
                  end else begin
                     cnt   <= 4'(LATENCY - 2);
                     state <= WAIT;
                  end
               end
            end
            WAIT: begin
               if (cnt == 4'd0) state <= DONE;
               else             cnt   <= cnt - 4'd1;
            end
            DONE: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
            default: begin
               state <= IDLE;
               busy  <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_dmem_responder.sv
// Directed bench for dmem_responder: six instances covering LATENCY 1/2/3/4/15 and DEPTH 16.
module tb_dmem_responder;

   localparam int N = 6;
   localparam int LAT [N] = '{2, 1, 3, 15, 4, 2};
   localparam int DEP [N] = '{1024, 1024, 1024, 1024, 1024, 16};

   logic          clk = 1'b0;
   logic          reset;
   logic [31:0]   addr;
   logic [31:0]   data_wr;
   logic          rd;
   logic [3:0]    mask;
   logic [N-1:0]  cs_v;
   logic [N-1:0]  valid_a;
   logic [N-1:0]  busy_a;
   logic [N-1:0]  err_a;
   logic [31:0]   data_a [N];

   int checks = 0;
   int errors = 0;

   always #5 clk = ~clk;

   for (genvar g = 0; g < N; g++) begin : g_dut
      dmem_responder #(.DEPTH(DEP[g]), .LATENCY(LAT[g])) u_dut (
         .clk     (clk),
         .reset   (reset),
         .addr    (addr),
         .data_wr (data_wr),
         .cs      (cs_v[g]),
         .rd      (rd),
         .mask    (mask),
         .data_rd (data_a[g]),
         .valid   (valid_a[g]),
         .busy    (busy_a[g])
`ifdef DMEM_RESP_RANGE_CHK_EN
         ,
         .err     (err_a[g])
`endif
      );
   end

`ifndef DMEM_RESP_RANGE_CHK_EN
   assign err_a = '0;
`endif

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed %h expected %h", tag, obs, exp);
      end
   endtask

   // One request on instance k; returns edges from accept to valid, load data and err
   task automatic do_req(input int k, input logic [31:0] a, input logic [31:0] d,
                         input logic r, input logic [3:0] m,
                         output int lat, output logic [31:0] q, output logic e);
      addr = a; data_wr = d; rd = r; mask = m; cs_v[k] = 1'b1;
      @(posedge clk); #1;
      cs_v[k] = 1'b0;
      lat = 1;
      while (!valid_a[k] && lat < 40) begin
         @(posedge clk); #1;
         lat++;
      end
      q = data_a[k];
      e = err_a[k];
      @(posedge clk); #1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int          lat;
      logic [31:0] q;
      logic        e;
      int          L;
      int          pulses;
      int          extra;

      reset = 1'b1; cs_v = '0; addr = '0; data_wr = '0; rd = 1'b0; mask = 4'h0;
      repeat (3) @(posedge clk);
      #1;
      chk("rst_valid", {31'b0, valid_a[0]}, 32'd0);
      chk("rst_busy",  {31'b0, busy_a[0]},  32'd0);
      chk("rst_data",  data_a[0], 32'h0);
      chk("rst_err",   {31'b0, err_a[5]},   32'd0);
      reset = 1'b0;
      @(posedge clk); #1;

      // Store DEADBEEF to 0x10 with cycle-by-cycle checks
      addr = 32'h10; data_wr = 32'hDEADBEEF; rd = 1'b0; mask = 4'hF; cs_v[0] = 1'b1;
      @(posedge clk); #1;
      cs_v[0] = 1'b0;
      chk("st_c1_busy",  {31'b0, busy_a[0]},  32'd1);
      chk("st_c1_valid", {31'b0, valid_a[0]}, 32'd0);
      @(posedge clk); #1;
      chk("st_c2_busy",  {31'b0, busy_a[0]},  32'd1);
      chk("st_c2_valid", {31'b0, valid_a[0]}, 32'd1);
      @(posedge clk); #1;
      chk("st_c3_busy",  {31'b0, busy_a[0]},  32'd0);
      chk("st_c3_valid", {31'b0, valid_a[0]}, 32'd0);
      do_req(0, 32'h10, 32'h0, 1'b1, 4'hF, lat, q, e);
      chk("ld10_lat",  lat, 32'd2);
      chk("ld10_data", q, 32'hDEADBEEF);

      // Byte masking
      do_req(0, 32'h20, 32'h11223344, 1'b0, 4'hF, lat, q, e);
      do_req(0, 32'h20, 32'hAABBCCDD, 1'b0, 4'h4, lat, q, e);
      do_req(0, 32'h20, 32'h0, 1'b1, 4'hF, lat, q, e);
      chk("mask_ld_full", q, 32'h11BB3344);
      do_req(0, 32'h20, 32'h0, 1'b1, 4'h3, lat, q, e);
      chk("mask_ld_low", q, 32'h00003344);
      do_req(0, 32'h20, 32'hFFFFFFFF, 1'b0, 4'h0, lat, q, e);
      chk("mask0_lat", lat, 32'd2);
      chk("store_keeps_data_rd", data_a[0], 32'h00003344);
      do_req(0, 32'h20, 32'h0, 1'b1, 4'hF, lat, q, e);
      chk("mask0_unchanged", q, 32'h11BB3344);
      do_req(0, 32'h20, 32'h0, 1'b1, 4'h3, lat, q, e);

      // Inputs toggled during WAIT/DONE are ignored
      addr = 32'h40; data_wr = 32'h12345678; rd = 1'b0; mask = 4'hF; cs_v[0] = 1'b1;
      @(posedge clk); #1;
      addr = 32'h44; data_wr = 32'hFFFFFFFF; rd = 1'b1; mask = 4'h0;
      @(posedge clk); #1;
      chk("ign_valid", {31'b0, valid_a[0]}, 32'd1);
      cs_v[0] = 1'b0;
      @(posedge clk); #1;
      chk("ign_idle_busy", {31'b0, busy_a[0]}, 32'd0);
      extra = 0;
      repeat (4) begin
         if (valid_a[0]) extra++;
         @(posedge clk); #1;
      end
      chk("ign_no_extra_valid", extra, 32'd0);
      chk("ign_data_rd_held", data_a[0], 32'h00003344);
      do_req(0, 32'h40, 32'h0, 1'b1, 4'hF, lat, q, e);
      chk("ign_ld40", q, 32'h12345678);

      // Reset together with cs: reset wins
      reset = 1'b1; addr = 32'h10; rd = 1'b1; mask = 4'hF; cs_v[0] = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0; cs_v[0] = 1'b0;
      chk("rstcs_busy", {31'b0, busy_a[0]}, 32'd0);
      chk("rstcs_data", data_a[0], 32'h0);
      @(posedge clk); #1;
      chk("rstcs_valid", {31'b0, valid_a[0]}, 32'd0);

      // Latency sweep: 10 back-to-back loads with cs held high
      for (int s = 1; s <= 3; s++) begin
         L = LAT[s];
         pulses = 0;
         addr = 32'h10; rd = 1'b1; mask = 4'hF; cs_v[s] = 1'b1;
         for (int c = 0; c < 12 * (L + 1) + 5; c++) begin
            @(posedge clk); #1;
            if (valid_a[s]) begin
               chk("sweep_pos", c, pulses * (L + 1) + L - 1);
               pulses++;
               if (pulses == 10) cs_v[s] = 1'b0;
            end
         end
         cs_v[s] = 1'b0;
         chk("sweep_count", pulses, 32'd10);
      end

      // Reset during WAIT with LATENCY=4
      do_req(4, 32'h30, 32'h000000AA, 1'b0, 4'hF, lat, q, e);
      chk("l4_lat", lat, 32'd4);
      addr = 32'h30; data_wr = 32'h55; rd = 1'b0; mask = 4'hF; cs_v[4] = 1'b1;
      @(posedge clk); #1;
      cs_v[4] = 1'b0;
      @(posedge clk); #1;
      reset = 1'b1;
      @(posedge clk); #1;
      reset = 1'b0;
      chk("rstwait_busy",  {31'b0, busy_a[4]},  32'd0);
      chk("rstwait_valid", {31'b0, valid_a[4]}, 32'd0);
      extra = 0;
      repeat (6) begin
         @(posedge clk); #1;
         if (valid_a[4]) extra++;
      end
      chk("rstwait_no_valid", extra, 32'd0);
      do_req(4, 32'h30, 32'h0, 1'b1, 4'hF, lat, q, e);
      chk("rstwait_old_data", q, 32'h000000AA);

      // Out-of-range word index with DEPTH=16
      do_req(5, 32'h00, 32'hCAFEF00D, 1'b0, 4'hF, lat, q, e);
      do_req(5, 32'h40, 32'h5A5A5A5A, 1'b0, 4'hF, lat, q, e);
      chk("rng_st_lat", lat, 32'd2);
`ifdef DMEM_RESP_RANGE_CHK_EN
      chk("rng_st_err", {31'b0, e}, 32'd1);
      do_req(5, 32'h00, 32'h0, 1'b1, 4'hF, lat, q, e);
      chk("rng_ld0_data", q, 32'hCAFEF00D);
      chk("rng_ld0_err", {31'b0, e}, 32'd0);
      do_req(5, 32'h40, 32'h0, 1'b1, 4'hF, lat, q, e);
      chk("rng_ld40_data", q, 32'h0);
      chk("rng_ld40_err", {31'b0, e}, 32'd1);
      @(posedge clk); #1;
      chk("rng_err_drop", {31'b0, err_a[5]}, 32'd0);
`else
      do_req(5, 32'h00, 32'h0, 1'b1, 4'hF, lat, q, e);
      chk("wrap_ld0_data", q, 32'h5A5A5A5A);
      do_req(5, 32'h40, 32'h0, 1'b1, 4'hF, lat, q, e);
      chk("wrap_ld40_data", q, 32'h5A5A5A5A);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
